// File: rtl/psum_ofifo_pkg.sv
// Shared constants and helpers for the MAC-array output collector.
package psum_ofifo_pkg;
  localparam int COL         = 8;
  localparam int PSUM_BW     = 16;
  localparam int OFIFO_DEPTH = 64;

  // Address bits plus one wrap bit distinguishes full from empty.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/psum_fifo_col.sv
// Single-column synchronous FIFO with first-word-fall-through output.
module psum_fifo_col
  import psum_ofifo_pkg::*;
#(
  parameter int DATA_W = PSUM_BW,
  parameter int DEPTH  = OFIFO_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr,
  input  logic [DATA_W-1:0] din,
  input  logic              rd,
  output logic [DATA_W-1:0] dout,
  output logic              empty,
  output logic              full,
  output logic              overflow
);
  localparam int PW = ptr_w(DEPTH);
  localparam int AW = PW - 1;

  logic [PW-1:0]     wptr;
  logic [PW-1:0]     rptr;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              do_wr;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);

  // rd is already qualified by the top, so a pop frees a slot this cycle.
  assign do_wr    = wr && (!full || rd);
  assign overflow = wr && full && !rd;

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_wr) wptr <= wptr + PW'(1);
      if (rd)    rptr <= rptr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && do_wr) mem[wptr[AW-1:0]] <= din;
  end

  assign dout = empty ? '0 : mem[rptr[AW-1:0]];
endmodule

// File: rtl/psum_ofifo.sv
// De-skewing output collector: one FIFO per MAC column, popped in lockstep.
module psum_ofifo
  import psum_ofifo_pkg::*;
#(
  parameter int col     = COL,
  parameter int psum_bw = PSUM_BW,
  parameter int depth   = OFIFO_DEPTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [col-1:0]         wr,
  input  logic [psum_bw*col-1:0] in,
  input  logic                   rd,
  output logic [psum_bw*col-1:0] out,
  output logic                   o_valid,
  output logic                   o_full,
  output logic                   o_ready,
  output logic                   o_overflow,
  output logic                   o_underflow
);
  logic [col-1:0] empty;
  logic [col-1:0] full;
  logic [col-1:0] ovf;
  logic           rd_eff;

  assign o_valid = &(~empty);
  assign o_full  = |full;
  assign o_ready = ~o_full;
  assign rd_eff  = rd & o_valid;

  for (genvar g = 0; g < col; g++) begin : g_col
    psum_fifo_col #(
      .DATA_W(psum_bw),
      .DEPTH (depth)
    ) u_col (
      .clk     (clk),
      .reset   (reset),
      .wr      (wr[g]),
      .din     (in[psum_bw*g +: psum_bw]),
      .rd      (rd_eff),
      .dout    (out[psum_bw*g +: psum_bw]),
      .empty   (empty[g]),
      .full    (full[g]),
      .overflow(ovf[g])
    );
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      o_overflow  <= 1'b0;
      o_underflow <= 1'b0;
    end else begin
      if (|ovf)          o_overflow  <= 1'b1;
      if (rd && !o_valid) o_underflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_psum_ofifo.sv
// Scoreboard bench for psum_ofifo: stimulus pushes expected rows, a monitor checks pops.
module tb_psum_ofifo;
  localparam int C  = 8;
  localparam int BW = 16;
  localparam int W  = C * BW;

  logic         clk = 1'b0;
  logic         reset;
  logic [C-1:0] wr;
  logic [W-1:0] in;
  logic         rd;
  logic [W-1:0] out;
  logic         o_valid, o_full, o_ready, o_overflow, o_underflow;

  int vectors = 0;
  int miscompares = 0;
  logic [W-1:0] exp_q[$];

  psum_ofifo #(.col(C), .psum_bw(BW), .depth(64)) dut (
    .clk        (clk),
    .reset      (reset),
    .wr         (wr),
    .in         (in),
    .rd         (rd),
    .out        (out),
    .o_valid    (o_valid),
    .o_full     (o_full),
    .o_ready    (o_ready),
    .o_overflow (o_overflow),
    .o_underflow(o_underflow)
  );

  always #5 clk = ~clk;

  // Monitor: whenever a valid pop is presented, the head row must match the scoreboard.
  always @(negedge clk) begin
    if (!reset && rd && o_valid) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL pop_unexpected: out=%h with empty scoreboard", out);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        if (out !== e) begin
          miscompares++;
          $display("FAIL pop_data: out=%h expected=%h", out, e);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic write_row(input logic [BW-1:0] v, input bit expect_pop);
    wr = '1;
    in = {C{v}};
    if (expect_pop) exp_q.push_back({C{v}});
    step();
    wr = '0;
  endtask

  task automatic pop_rows(input int n);
    rd = 1'b1;
    for (int k = 0; k < n; k++) step();
    rd = 1'b0;
  endtask

  initial begin
    reset = 1'b1; wr = '0; in = '0; rd = 1'b0;
    step(); step();
    reset = 1'b0;
    step();

    check("rst_out", out, '0);
    check("rst_valid", W'(o_valid), W'(0));
    check("rst_ready", W'(o_ready), W'(1));
    check("rst_full", W'(o_full), W'(0));
    check("rst_ovf", W'(o_overflow), W'(0));
    check("rst_unf", W'(o_underflow), W'(0));

    // Skewed fill: column i arrives in cycle i.
    for (int i = 0; i < C; i++) begin
      logic [BW-1:0] v;
      v  = BW'(17 * (i + 1));
      wr = C'(1) << i;
      in = W'(v) << (BW * i);
      step();
      check("skew_valid", W'(o_valid), (i == C - 1) ? W'(1) : W'(0));
    end
    wr = '0;
    check("skew_out", out, 128'h0088_0077_0066_0055_0044_0033_0022_0011);
    exp_q.push_back(128'h0088_0077_0066_0055_0044_0033_0022_0011);
    pop_rows(1);
    check("skew_after_pop", W'(o_valid), W'(0));

    // Fill to full, then drain.
    for (int r = 0; r < 64; r++) write_row(BW'(r), 1'b1);
    check("full_flag", W'(o_full), W'(1));
    check("full_ready", W'(o_ready), W'(0));
    pop_rows(64);
    check("drained_valid", W'(o_valid), W'(0));

    // Refill with pointers wrapped.
    for (int r = 0; r < 64; r++) write_row(BW'(100 + r), 1'b1);
    check("wrap_full", W'(o_full), W'(1));

    // Write and pop together at full: occupancy stays put, no drop.
    wr = '1; in = {C{16'h0BEE}}; rd = 1'b1;
    exp_q.push_back({C{16'h0BEE}});
    step();
    wr = '0; rd = 1'b0;
    check("wrpop_full", W'(o_full), W'(1));
    check("wrpop_ovf", W'(o_overflow), W'(0));
    check("wrpop_head", out, {C{16'd101}});

    // Write while full without a pop is dropped.
    write_row(16'hDEAD, 1'b0);
    check("ovf_set", W'(o_overflow), W'(1));
    pop_rows(64);
    check("ovf_drained", W'(o_valid), W'(0));
    check("ovf_sticky", W'(o_overflow), W'(1));

    // Pop while empty.
    rd = 1'b1; step(); rd = 1'b0;
    check("unf_set", W'(o_underflow), W'(1));
    step(); step();
    check("unf_sticky", W'(o_underflow), W'(1));
    write_row(16'h5A5A, 1'b1);
    check("unf_ptr_valid", W'(o_valid), W'(1));
    pop_rows(1);

    // Reset with data queued.
    for (int r = 0; r < 10; r++) write_row(BW'(16'h0200 + r), 1'b0);
    check("pre_rst_valid", W'(o_valid), W'(1));
    reset = 1'b1; step(); reset = 1'b0;
    check("mid_rst_valid", W'(o_valid), W'(0));
    check("mid_rst_out", out, '0);
    check("mid_rst_ovf", W'(o_overflow), W'(0));
    check("mid_rst_unf", W'(o_underflow), W'(0));
    check("mid_rst_ready", W'(o_ready), W'(1));
    write_row(16'h1357, 1'b1);
    check("post_rst_out", out, {C{16'h1357}});
    pop_rows(1);
    check("post_rst_empty", W'(o_valid), W'(0));

    check("scoreboard_empty", W'(exp_q.size()), W'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/psum_ofifo.md
Name: psum_ofifo

Overview:
- Output collector directly downstream of the MAC array.
- Each column drains its partial sums into its own synchronous FIFO, strobed by that column's valid bit. Columns finish at skewed times because instructions ripple row by row.
- Presents a full de-skewed output row (all columns) to the SRAM write-back path once every column holds at least one entry.
- Per-column FIFOs are popped in lockstep.

Parameters:
- col, 8, number of columns (independent FIFOs).
- psum_bw, 16, partial-sum width per column.
- depth, 64, entries per column FIFO; power of two, >= 2.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- wr  input  col  per-column write strobe (array valid vector).
- in  input  psum_bw*col  column data; column i at bits [psum_bw*(i+1)-1 : psum_bw*i].
- rd  input  1  pop one row from all columns.
- out  output  psum_bw*col  head row, same packing as in.
- o_valid  output  1  every column non-empty; out is meaningful.
- o_full  output  1  any column full.
- o_ready  output  1  equals ~o_full.
- o_overflow  output  1  sticky: a write was dropped.
- o_underflow  output  1  sticky: rd asserted while o_valid low.

Behaviour:
- All state changes on posedge clk. reset has priority over every other input.
- Reset:
  - all read/write pointers 0, so every column is empty.
  - o_valid=0, o_full=0, o_ready=1, o_overflow=0, o_underflow=0.
  - out=0, because empty columns drive zero.
  - Memory contents are not reset.
- Reset mid-operation empties all FIFOs in that cycle. Queued data is discarded and sticky flags clear.
- Pointers: log2(depth)+1 bits; the MSB is the wrap bit.
  - empty[i] = (wptr==rptr).
  - full[i] = (addresses equal && wrap bits differ).
  - Pointers wrap naturally modulo 2*depth.
- Write, column i: when wr[i]=1, in[i] is stored at wptr[i] and wptr[i] increments, provided either:
  - full[i]=0, or
  - a valid pop occurs in the same cycle.
  - Otherwise the write is dropped and o_overflow sets.
- Read: a pop is valid when rd=1 and o_valid=1. On a valid pop, all column rptrs increment together.
  - rd=1 with o_valid=0 is ignored (no pointer change) and sets o_underflow.
- Simultaneous write+pop on a column: both happen and the occupancy of that column is unchanged. This holds at full and at one-entry levels.
- Output timing: first-word-fall-through.
  - out[i] = mem_i[rptr[i]] combinationally when column i is non-empty, otherwise 0.
  - Write-to-visible latency is 1 cycle: data written at edge N is on out after edge N.
  - o_valid rises the cycle after the last-arriving column receives its first entry.
- Flags are combinational from pointers (o_full, o_ready, o_valid) or registered sticky bits (o_overflow, o_underflow).
- Columns may hold different occupancies. o_valid depends only on the minimum occupancy.
- Data is stored unmodified; no arithmetic.

Decomposition:
- Shared package holds:
  - default constants COL=8, PSUM_BW=16, OFIFO_DEPTH=64.
  - the pointer-width function clog2(depth)+1.
- One natural sub-module: psum_fifo_col. It is a single-column sync FIFO with ports:
  - clk, reset, wr, din, rd, dout, empty, full, overflow.
- psum_ofifo instantiates col copies with a generate loop and derives:
  - rd_eff = rd & o_valid.
  - o_valid = AND of ~empty.
  - o_full = OR of full.

Test Plan:
- Reset then idle: out=0, o_valid=0, o_ready=1, o_full=0, both sticky flags 0.
- Skewed fill: wr=8'b00000001 with col0=16'h0011, then wr bit i set in cycle i with column i data 16'h0011*(i+1). o_valid stays 0 until the cycle after column 7 writes, then out holds 16'h0011..16'h0088. A pop then returns o_valid=0.
- Fill all columns with 64 rows (value = row index): o_full=1, o_ready=0. A 65th write with wr=8'hFF sets o_overflow and the data is dropped. Popping 64 rows returns 0..63 in order, with a wrap check by refilling once more.
- Full + simultaneous wr=8'hFF and rd=1: occupancy stays 64, no overflow, head advances by one row, and the new row is read last.
- rd=1 while empty: no pointer change, o_underflow=1 and stays 1 until reset.
- Reset asserted mid-stream with 10 rows queued: next cycle o_valid=0, out=0, flags 0. A subsequent single-row write is read correctly.
